// File: rtl/scoreboard_hazard_pkg.sv
// Shared definitions for the decode-stage register scoreboard and its per-register entries.
package scoreboard_hazard_pkg;

    localparam int LAT_W_DEF = 2;
    localparam int REG_IDX_W = 5;
    localparam logic [REG_IDX_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic                 busy;
        logic [LAT_W_DEF-1:0] cnt;
    } sb_entry_t;

endpackage

// File: rtl/scoreboard_hazard_sb_entry.sv
// One scoreboard slot: tracks whether a register has a write in flight and how many
// cycles remain until that write's writeback is due.
module sb_entry
    import scoreboard_hazard_pkg::*;
#(
    parameter int LAT_W = LAT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_cnt,
    input  logic             clear,
    output logic             busy,
    output logic [LAT_W-1:0] cnt
);

    // A new issue outranks a same-cycle writeback so the younger write stays tracked.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            busy <= 1'b1;
            cnt  <= load_cnt;
        end else if (clear) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (busy && cnt != '0) begin
            cnt <= cnt - LAT_W'(1);
        end
    end

endmodule

// File: rtl/scoreboard_hazard.sv
// Decode-stage scoreboard: detects RAW/WAW hazards against in-flight writes and bypasses
// the current writeback value onto every source operand port.
module scoreboard_hazard
    import scoreboard_hazard_pkg::*;
#(
    parameter int NUM_REGS  = 32,
    parameter int SRC_PORTS = 2,
    parameter int LAT_W     = LAT_W_DEF,
    parameter int DWIDTH    = 32,
    parameter int PERF_W    = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           issue_valid,
    input  logic                           issue_kill,
    input  logic                           issue_we,
    input  logic [REG_IDX_W-1:0]           issue_rd,
    input  logic [LAT_W-1:0]               issue_lat,
    input  logic [REG_IDX_W*SRC_PORTS-1:0] issue_src,
    input  logic [SRC_PORTS-1:0]           issue_src_used,
    input  logic [DWIDTH*SRC_PORTS-1:0]    rf_rdata,
    input  logic                           wb_valid,
    input  logic [REG_IDX_W-1:0]           wb_rd,
    input  logic [DWIDTH-1:0]              wb_data,
    output logic [DWIDTH*SRC_PORTS-1:0]    src_data,
    output logic                           stall,
    output logic [PERF_W-1:0]              stall_count,
    output logic                           proto_err
);

    logic [NUM_REGS-1:0]  busy;
    logic [LAT_W-1:0]     cnt [NUM_REGS];
    logic [LAT_W-1:0]     lat_m1;
    logic                 accept;
    logic                 raw_hazard;
    logic                 waw_hazard;
    logic [REG_IDX_W-1:0] src_addr [SRC_PORTS];
    logic [DWIDTH-1:0]    rf_word  [SRC_PORTS];

    assign lat_m1  = issue_lat - LAT_W'(1);
    assign busy[0] = 1'b0;
    assign cnt[0]  = '0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        sb_entry #(
            .LAT_W(LAT_W)
        ) u_entry (
            .clk     (clk),
            .rst     (rst),
            .load    (accept && issue_rd == REG_IDX_W'(r)),
            .load_cnt(lat_m1),
            .clear   (wb_valid && wb_rd == REG_IDX_W'(r)),
            .busy    (busy[r]),
            .cnt     (cnt[r])
        );
    end

    for (genvar p = 0; p < SRC_PORTS; p++) begin : g_port
        assign src_addr[p] = issue_src[REG_IDX_W*p +: REG_IDX_W];
        assign rf_word[p]  = rf_rdata[DWIDTH*p +: DWIDTH];
    end

    // A source whose writeback lands this very cycle is bypassed instead of stalling.
    always_comb begin
        raw_hazard = 1'b0;
        src_data   = '0;
        for (int i = 0; i < SRC_PORTS; i++) begin
            if (src_addr[i] == REG_ZERO) begin
                src_data[DWIDTH*i +: DWIDTH] = '0;
            end else if (wb_valid && wb_rd == src_addr[i]) begin
                src_data[DWIDTH*i +: DWIDTH] = wb_data;
            end else begin
                src_data[DWIDTH*i +: DWIDTH] = rf_word[i];
            end
            if (issue_src_used[i] && src_addr[i] != REG_ZERO && busy[src_addr[i]]
                && !(wb_valid && wb_rd == src_addr[i])) begin
                raw_hazard = 1'b1;
            end
        end
    end

    // An older write that would still be pending when the new one lands must drain first.
    assign waw_hazard = issue_we && issue_rd != REG_ZERO && busy[issue_rd]
                        && (cnt[issue_rd] >= lat_m1);
    assign stall      = issue_valid && !issue_kill && (raw_hazard || waw_hazard);
    assign accept     = issue_valid && !issue_kill && !stall && issue_we
                        && issue_rd != REG_ZERO;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall && stall_count != '1) begin
            stall_count <= stall_count + PERF_W'(1);
        end
    end

    // Writes to x0 are architectural no-ops and are not treated as protocol violations.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            proto_err <= 1'b0;
        end else if (wb_valid && wb_rd != REG_ZERO
                     && (!busy[wb_rd] || cnt[wb_rd] != '0)) begin
            proto_err <= 1'b1;
        end
    end

endmodule
